// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO read-side stream controller.
// Imported by fifo_stream_reader and its skid buffer.
package fifo_stream_reader_pkg;

   localparam int DW_DEF     = 16;
   localparam int SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/fifo_stream_reader_skid.sv
// Two-entry skid buffer: push into tail, pop from head, strict FIFO order.
// Head is the registered downstream data word.
module fifo_stream_reader_skid
   import fifo_stream_reader_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [1:0]    occ,
   output logic [DW-1:0] head
);

   logic [DW-1:0] tail;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ  <= 2'd0;
         head <= '0;
         tail <= '0;
      end else begin
         unique case (occ)
            2'd0: begin
               if (push) begin
                  head <= push_data;
                  occ  <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  head <= push_data;
               end else if (push) begin
                  tail <= push_data;
                  occ  <= 2'd2;
               end else if (pop) begin
                  occ  <= 2'd0;
               end
            end
            2'd2: begin
               if (pop) begin
                  head <= tail;
                  if (push) tail <= push_data;
                  else      occ  <= 2'd1;
               end
            end
            default: occ <= 2'd0;
         endcase
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller: pops a 1-cycle-latency FIFO into a valid/ready
// stream through a 2-entry skid buffer, with run/drain control.
module fifo_stream_reader
   import fifo_stream_reader_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [DW-1:0]    fifo_rdata,
   output logic             m_valid,
   output logic [DW-1:0]    m_data,
   input  logic             m_ready,
   output logic [CNT_W-1:0] rd_count,
   output logic             busy
);

   state_t     state;
   logic       inflight;
   logic       pop;
   logic [1:0] occ;
   logic [2:0] level;
   logic [2:0] room;

   assign m_valid = (occ != 2'd0);
   assign pop     = m_valid & m_ready;
   assign busy    = (state != IDLE);

   // A pop at this edge frees a slot, so it widens the read window by one.
   assign level      = {1'b0, occ} + {2'b0, inflight};
   assign room       = 3'(SKID_DEPTH) + {2'b0, pop};
   assign fifo_rd_en = (state == RUN) & enable & ~fifo_empty & (level < room);

   fifo_stream_reader_skid #(.DW(DW)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight),
      .push_data (fifo_rdata),
      .pop       (pop),
      .occ       (occ),
      .head      (m_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         inflight <= 1'b0;
         rd_count <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (pop) rd_count <= rd_count + 1'b1;
         unique case (state)
            IDLE:  if (enable) state <= RUN;
            RUN:   if (!enable) state <= DRAIN;
            DRAIN: begin
               if (enable)
                  state <= RUN;
               else if (occ == 2'd0 && !inflight)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader against a 1-cycle-latency FIFO
// model; expected words are queued as they are written into the FIFO.
module tb_fifo_stream_reader;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [15:0] fifo_rdata;
   logic        m_valid;
   logic [15:0] m_data;
   logic        m_ready;
   logic [3:0]  rd_count;
   logic        busy;

   fifo_stream_reader #(.DW(16), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_rdata (fifo_rdata),
      .m_valid    (m_valid),
      .m_data     (m_data),
      .m_ready    (m_ready),
      .rd_count   (rd_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem [0:255];
   int          wp = 0;
   int          rp = 0;

   assign fifo_empty = (wp == rp);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rdata <= mem[rp[7:0]];
         rp         <= rp + 1;
      end
   end

   logic [15:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          delivered = 0;
   int          pops = 0;
   int          strobes = 0;
   logic [3:0]  cnt_model = '0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] v);
      mem[wp[7:0]] = v;
      wp++;
      exp_q.push_back(v);
   endtask

   task automatic sample();
      logic [15:0] e;
      if (!rst_n) begin
         cnt_model = '0;
         while (delivered < rp) begin
            void'(exp_q.pop_front());
            delivered++;
         end
      end else begin
         check("rd_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
         check("occ_le_2", 32'(dut.u_buf.occ <= 2'd2), 32'd1);
         check("rd_count", 32'(rd_count), 32'(cnt_model));
         if (fifo_rd_en) strobes++;
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_word", 32'(m_data), 32'hffff_ffff);
            end else begin
               e = exp_q.pop_front();
               check("m_data", 32'(m_data), 32'(e));
            end
            cnt_model = cnt_model + 4'd1;
            delivered++;
            pops++;
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag, input int max);
      int i;
      for (i = 0; i < max && exp_q.size() != 0; i++) cyc();
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      logic [6:0]  rd_pat;
      logic [6:0]  v_pat;
      logic [15:0] first;
      int          p0;
      int          s0;
      int          i;

      rst_n   = 1'b0;
      enable  = 1'b0;
      m_ready = 1'b1;
      cyc();
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_rd_count", 32'(rd_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);

      // basic streaming of 3,4,5,6
      rst_n = 1'b1;
      for (int k = 3; k <= 6; k++) push_word(16'(k));
      cyc();
      check("idle_no_rd", 32'(fifo_rd_en), 32'd0);
      enable = 1'b1;
      for (i = 0; i < 10 && !fifo_rd_en; i++) cyc();
      check("first_strobe", 32'(fifo_rd_en), 32'd1);
      for (int k = 0; k < 7; k++) begin
         rd_pat[6-k] = fifo_rd_en;
         v_pat[6-k]  = m_valid;
         cyc();
      end
      check("rd_pattern", 32'(rd_pat), 32'h78);
      check("valid_pattern", 32'(v_pat), 32'h1e);
      check("count_4", 32'(rd_count), 32'd4);
      check("busy_run", 32'(busy), 32'd1);

      // backpressure
      m_ready = 1'b0;
      first   = 16'h0007;
      for (int k = 0; k < 8; k++) push_word(first + 16'(k));
      s0 = strobes;
      repeat (5) cyc();
      check("stall_strobes", 32'(strobes - s0), 32'd2);
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_hold", 32'(m_data), 32'(first));
      m_ready = 1'b1;
      wait_drain("bp_drain", 40);

      // alternating ready
      m_ready = 1'b0;
      for (int k = 0; k < 12; k++) push_word(16'h0100 + 16'(k));
      for (i = 0; i < 10 && !m_valid; i++) cyc();
      check("alt_valid", 32'(m_valid), 32'd1);
      p0 = pops;
      for (int k = 0; k < 16; k++) begin
         m_ready = (k % 2 == 0);
         cyc();
      end
      check("alt_throughput", 32'(pops - p0), 32'd8);
      m_ready = 1'b1;
      wait_drain("alt_drain", 40);

      // drain with one word buffered and one in flight
      m_ready = 1'b0;
      push_word(16'h0200);
      push_word(16'h0201);
      for (i = 0; i < 10 && !(dut.inflight && dut.u_buf.occ == 2'd1); i++)
         cyc();
      check("drain_setup", 32'(dut.inflight && dut.u_buf.occ == 2'd1), 32'd1);
      enable = 1'b0;
      p0 = pops;
      cyc();
      check("drain_busy", 32'(busy), 32'd1);
      m_ready = 1'b1;
      wait_drain("drain_flush", 20);
      repeat (3) cyc();
      check("drain_words", 32'(pops - p0), 32'd2);
      check("drain_idle", 32'(busy), 32'd0);
      push_word(16'h0300);
      s0 = strobes;
      repeat (3) cyc();
      check("idle_strobes", 32'(strobes - s0), 32'd0);

      // reset mid-stream with a full buffer
      m_ready = 1'b0;
      enable  = 1'b1;
      for (int k = 1; k < 4; k++) push_word(16'h0300 + 16'(k));
      for (i = 0; i < 20 && dut.u_buf.occ != 2'd2; i++) cyc();
      check("full_setup", 32'(dut.u_buf.occ), 32'd2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(m_valid), 32'd0);
      check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("mid_rst_count", 32'(rd_count), 32'd0);
      cyc();
      rst_n   = 1'b1;
      m_ready = 1'b1;
      wait_drain("resume_drain", 40);

      // counter wrap: 17 transfers into a 4-bit counter
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 17; k++) push_word(16'h0400 + 16'(k));
      wait_drain("wrap_drain", 60);
      repeat (3) cyc();
      check("wrap_count", 32'(rd_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side controller for the 16-bit synchronous FIFO. It pops words from the FIFO read port, which has a 1-cycle read latency, and presents them on a registered valid/ready stream to a downstream consumer. A 2-entry skid buffer gives full throughput under backpressure. An enable input and a three-state controller allow clean start and drain.

Parameters:
DW, 16, data width; matches the FIFO data_in/data_out width
CNT_W, 16, width of the delivered-word counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  level; 1 = fetch from FIFO, 0 = stop fetching and drain
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO read strobe
fifo_rdata  input  DW  FIFO read data; valid in the cycle after fifo_rd_en is sampled
m_valid  output  1  downstream data valid
m_data  output  DW  downstream data
m_ready  input  1  downstream accept
rd_count  output  CNT_W  count of completed downstream transfers
busy  output  1  1 when state is not IDLE

Behaviour:
- Reset (rst_n low, async): m_valid=0, m_data=0, rd_count=0, busy=0, fifo_rd_en=0. Buffer is cleared, in-flight flag is cleared, state=IDLE. Reset in the middle of a transfer discards buffered and in-flight words with no further outputs.
- Internal storage:
  - 2-entry buffer (head, tail) with an occupancy counter occ (0..2).
  - inflight flag: set when fifo_rd_en=1 at an edge, so the word arrives next cycle.
  - At the edge after a read, fifo_rdata is written to the tail. occ increments unless a pop happens at the same edge.
- Pop: pop = m_valid & m_ready at the edge. The head advances; if the tail is valid it moves to the head. Order is strictly FIFO.
- m_valid = (occ != 0). m_data = buffer head, registered. m_data holds its value while m_valid=1 and m_ready=0. m_data is don't-care when m_valid=0 but holds its last value.
- fifo_rd_en (combinational from registered state and inputs) = (state==RUN) & enable & ~fifo_empty & (occ + inflight - pop < 2). Same-cycle pop frees a slot, so sustained throughput is 1 word/clk with m_ready held high.
- Latency: fifo_rd_en sampled at edge N; data captured at edge N+1; m_valid=1 after N+1. First word appears 2 edges after the first read strobe.
- The block never issues fifo_rd_en while fifo_empty=1.
- Buffer overflow is impossible by construction. The bench asserts occ <= 2.
- rd_count increments by 1 on each pop and wraps modulo 2^CNT_W.
- FSM:
  - IDLE: busy=0, no reads. Go to RUN when enable=1.
  - RUN: reads allowed per the rule above. Go to DRAIN when enable=0.
  - DRAIN: no new reads. The in-flight word is still captured. Go to IDLE when occ==0, inflight==0 and no capture is pending. Go back to RUN if enable=1 again (takes priority over going to IDLE).
- Simultaneous capture and pop at occ=1: occ stays 1, head = new word. At occ=2 with inflight=1 the strobe rule prevents this.
- fifo_empty rising while a read is in flight: the in-flight word is still captured. No more reads until fifo_empty falls.

Decomposition:
- Shared package: DW default, the FSM state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2), and the buffer depth constant SKID_DEPTH=2.
- One sub-module is natural: skid_buf2 (2-entry buffer with push/pop, occ, head). The FSM, strobe logic and counter stay in the top level.

Test Plan:
- Reset then enable=1, FIFO preloaded with 3,4,5,6, m_ready=1 -> fifo_rd_en high for 4 consecutive cycles; m_data 3,4,5,6 on consecutive cycles starting 2 edges after the first strobe; rd_count=4; fifo_rd_en never high while empty.
- Backpressure: 8 words queued, m_ready low for 5 cycles then high -> at most 2 strobes while stalled; m_data holds the first word; all 8 words delivered in order, none lost or duplicated.
- Alternating m_ready (1,0,1,0...) with a continuous FIFO supply -> throughput 1 word per 2 clk; occ <= 2 throughout; sequence monotonic.
- Drop enable with 1 word in flight and 1 buffered -> busy stays 1 through DRAIN; exactly 2 more words delivered; then IDLE, busy=0, no strobes.
- Assert rst_n low mid-stream (occ=2) -> m_valid, fifo_rd_en and rd_count go to 0 immediately; after release, with enable=1, reading resumes from the current FIFO head.
- rd_count wrap with CNT_W=4: 17 transfers -> rd_count=1.
